// File: rtl/meteor_pkg.sv
// -----------------------------------------------------------------------------
// meteor_pkg
// Shared types and constants for the meteorite hit controller slice.
//   t_hit_state  : controller FSM states (IDLE, ARMED, FLASH, OVER)
//   t_tile       : 6-bit playfield tile coordinate
//   c_ScoreW     : width of the score output port (14 bits)
//   c_ScoreRegW  : width of the internal score register
//   to_bcd()     : converts a small integer constant to 4-digit BCD
// Optional feature macro: METEOR_SCORE_BCD_EN (BCD score instead of binary).
// -----------------------------------------------------------------------------
package meteor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FLASH = 2'd2,
        ST_OVER  = 2'd3
    } t_hit_state;

    typedef logic [5:0] t_tile;

    localparam int c_ScoreW = 14;

`ifdef METEOR_SCORE_BCD_EN
    // Four full BCD digits are kept internally so 9999 is representable; the
    // port only carries the low 14 bits (2-bit thousands digit).
    localparam int c_ScoreRegW = 16;
`else
    localparam int c_ScoreRegW = c_ScoreW;
`endif

    // Constant-time conversion of the per-hit increment into packed BCD.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/meteorite_hit_ctrl_if.sv
// -----------------------------------------------------------------------------
// meteorite_hit_ctrl_if
// Bundles the game-side signals of the meteorite hit controller.
//   slave  modport : the controller (consumes coordinates, drives pulses/state)
//   master modport : the game logic around it (drives coordinates, reads state)
// Inputs : i_GameActive, i_FrameTick, i_MeteX/Y, i_BulletValid, i_BulletX/Y, i_ShipX
// Outputs: o_MeteHit, o_BulletKill, o_ShipHit, o_Score, o_Lives, o_Flash, o_GameOver
// -----------------------------------------------------------------------------
interface meteorite_hit_ctrl_if;
    import meteor_pkg::*;

    logic                i_GameActive;
    logic                i_FrameTick;
    t_tile               i_MeteX;
    t_tile               i_MeteY;
    logic                i_BulletValid;
    t_tile               i_BulletX;
    t_tile               i_BulletY;
    t_tile               i_ShipX;

    logic                o_MeteHit;
    logic                o_BulletKill;
    logic                o_ShipHit;
    logic [c_ScoreW-1:0] o_Score;
    logic [2:0]          o_Lives;
    logic                o_Flash;
    logic                o_GameOver;

    modport slave (
        input  i_GameActive, i_FrameTick, i_MeteX, i_MeteY,
               i_BulletValid, i_BulletX, i_BulletY, i_ShipX,
        output o_MeteHit, o_BulletKill, o_ShipHit, o_Score,
               o_Lives, o_Flash, o_GameOver
    );

    modport master (
        output i_GameActive, i_FrameTick, i_MeteX, i_MeteY,
               i_BulletValid, i_BulletX, i_BulletY, i_ShipX,
        input  o_MeteHit, o_BulletKill, o_ShipHit, o_Score,
               o_Lives, o_Flash, o_GameOver
    );

endinterface

// File: rtl/meteor_score_acc.sv
// -----------------------------------------------------------------------------
// meteor_score_acc
// Combinational "score + c_HitPoints, saturated" for the hit controller.
//   i_Score : current score register (c_ScoreRegW bits)
//   o_Next  : score after one meteorite kill
// Default build: binary add through a 15-bit intermediate, clamp at c_ScoreMax.
// METEOR_SCORE_BCD_EN defined: 4-digit BCD add with per-digit carry, clamp at
// BCD 9999 (c_ScoreMax unused).
// -----------------------------------------------------------------------------
module meteor_score_acc
    import meteor_pkg::*;
#(
    parameter int c_HitPoints = 10,
    parameter int c_ScoreMax  = 9999
) (
    input  logic [c_ScoreRegW-1:0] i_Score,
    output logic [c_ScoreRegW-1:0] o_Next
);

`ifdef METEOR_SCORE_BCD_EN

    localparam logic [15:0] c_AddBcd = to_bcd(c_HitPoints);

    logic [15:0] sum_bcd;
    logic [4:0]  digit_sum;
    logic        carry;

    always_comb begin
        // NOTE: every combinational variable gets a default first so no
        // path through the block leaves it unassigned (no latch inferred).
        sum_bcd   = '0;
        digit_sum = '0;
        carry     = 1'b0;
        for (int d = 0; d < 4; d++) begin
            digit_sum = 5'(i_Score[4*d +: 4]) + 5'(c_AddBcd[4*d +: 4]) + 5'(carry);
            if (digit_sum > 5'd9) begin
                sum_bcd[4*d +: 4] = 4'(digit_sum - 5'd10);
                carry             = 1'b1;
            end else begin
                sum_bcd[4*d +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
        // A carry out of the thousands digit means the result passed 9999.
        o_Next = carry ? 16'h9999 : sum_bcd;
    end

`else

    typedef logic [c_ScoreW:0] t_sum;

    localparam t_sum c_Add = t_sum'(c_HitPoints);
    localparam t_sum c_Max = t_sum'(c_ScoreMax);

    t_sum sum;

    always_comb begin
        // The extra bit keeps the carry so 16383 + n cannot wrap below the max.
        sum    = t_sum'(i_Score) + c_Add;
        o_Next = (sum > c_Max) ? c_Max[c_ScoreW-1:0] : sum[c_ScoreW-1:0];
    end

`endif

endmodule

// File: rtl/meteorite_hit_ctrl.sv
// -----------------------------------------------------------------------------
// meteorite_hit_ctrl
// Per-frame collision detector and game-state keeper for the meteorite game.
// Compares the meteorite tile against the bullet and ship tiles on each frame
// tick and issues registered one-cycle pulses to the bullet / meteorite
// controllers, while tracking score, lives, post-hit flash and game over.
// Ports:
//   i_Clk   : system / pixel clock
//   i_Rst_n : asynchronous active-low reset
//   bus     : meteorite_hit_ctrl_if.slave (coordinates in, pulses/state out)
// Optional feature macro: METEOR_SCORE_BCD_EN (BCD score in meteor_score_acc).
// -----------------------------------------------------------------------------
module meteorite_hit_ctrl
    import meteor_pkg::*;
#(
    parameter int c_GameWidth   = 40,
    parameter int c_GameHeight  = 30,
    parameter int c_Lives       = 3,
    parameter int c_HitPoints   = 10,
    parameter int c_ScoreMax    = 9999,
    parameter int c_FlashFrames = 8
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    meteorite_hit_ctrl_if.slave bus
);

    localparam t_tile      c_WidthTile  = t_tile'(c_GameWidth);
    localparam t_tile      c_HeightTile = t_tile'(c_GameHeight);
    localparam t_tile      c_ShipRow    = t_tile'(c_GameHeight - 2);
    localparam logic [2:0] c_LivesInit  = 3'(c_Lives);
    localparam logic [7:0] c_FlashInit  = 8'(c_FlashFrames);

    t_hit_state             state;
    logic                   mete_hit_q;
    logic                   bullet_kill_q;
    logic                   ship_hit_q;
    logic                   flash_q;
    logic                   game_over_q;
    logic [2:0]             lives_q;
    logic [7:0]             flash_cnt;
    logic [c_ScoreRegW-1:0] score_q;
    logic [c_ScoreRegW-1:0] score_next;

    logic       mete_on_screen;
    logic [6:0] mete_y_below;
    logic       bullet_hit;
    logic       ship_hit;

    // ------------------------------------------------------------------
    // Collision compares (combinational, consumed only on frame ticks)
    // ------------------------------------------------------------------
    assign mete_on_screen = (bus.i_MeteX < c_WidthTile) && (bus.i_MeteY < c_HeightTile);

    // Row below the meteorite, widened so row 63 + 1 cannot alias row 0.
    assign mete_y_below = {1'b0, bus.i_MeteY} + 7'd1;

    // The bullet may have stepped one row past the meteorite within a frame,
    // so the row directly below also counts as a hit.
    assign bullet_hit = mete_on_screen && bus.i_BulletValid
                     && (bus.i_BulletX == bus.i_MeteX)
                     && ((bus.i_BulletY == bus.i_MeteY)
                         || ({1'b0, bus.i_BulletY} == mete_y_below));

    assign ship_hit = mete_on_screen
                   && (bus.i_MeteX == bus.i_ShipX)
                   && (bus.i_MeteY == c_ShipRow);

    meteor_score_acc #(
        .c_HitPoints (c_HitPoints),
        .c_ScoreMax  (c_ScoreMax)
    ) u_score_acc (
        .i_Score (score_q),
        .o_Next  (score_next)
    );

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        // NOTE: all state lives in flops (no memories), so every register is
        // cleared by the async reset; sequential updates use <= only so the
        // order of statements below does not change what is sampled.
        if (!i_Rst_n) begin
            state         <= ST_IDLE;
            mete_hit_q    <= 1'b0;
            bullet_kill_q <= 1'b0;
            ship_hit_q    <= 1'b0;
            flash_q       <= 1'b0;
            game_over_q   <= 1'b0;
            lives_q       <= c_LivesInit;
            flash_cnt     <= '0;
            score_q       <= '0;
        end else begin
            // Pulses default low; a branch below raises them for one cycle.
            mete_hit_q    <= 1'b0;
            bullet_kill_q <= 1'b0;
            ship_hit_q    <= 1'b0;

            if (!bus.i_GameActive) begin
                // Game idle overrides everything; score, lives and the game
                // over flag stay visible until the next game starts.
                state   <= ST_IDLE;
                flash_q <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state       <= ST_ARMED;
                        score_q     <= '0;
                        lives_q     <= c_LivesInit;
                        game_over_q <= 1'b0;
                        flash_q     <= 1'b0;
                        flash_cnt   <= '0;
                    end

                    ST_ARMED: begin
                        if (bus.i_FrameTick) begin
                            if (bullet_hit) begin
                                // Bullet wins a same-frame tie with the ship.
                                mete_hit_q    <= 1'b1;
                                bullet_kill_q <= 1'b1;
                                score_q       <= score_next;
                            end else if (ship_hit) begin
                                mete_hit_q <= 1'b1;
                                ship_hit_q <= 1'b1;
                                if (lives_q <= 3'd1) begin
                                    lives_q     <= '0;
                                    game_over_q <= 1'b1;
                                    state       <= ST_OVER;
                                end else begin
                                    lives_q   <= lives_q - 3'd1;
                                    flash_q   <= 1'b1;
                                    flash_cnt <= c_FlashInit;
                                    state     <= ST_FLASH;
                                end
                            end
                        end
                    end

                    ST_FLASH: begin
                        // Ship is invulnerable here; bullets still score.
                        if (bus.i_FrameTick) begin
                            if (bullet_hit) begin
                                mete_hit_q    <= 1'b1;
                                bullet_kill_q <= 1'b1;
                                score_q       <= score_next;
                            end
                            if (flash_cnt <= 8'd1) begin
                                flash_q   <= 1'b0;
                                flash_cnt <= '0;
                                state     <= ST_ARMED;
                            end else begin
                                flash_cnt <= flash_cnt - 8'd1;
                            end
                        end
                    end

                    ST_OVER: begin
                        // Frozen until i_GameActive drops.
                        game_over_q <= 1'b1;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_MeteHit    = mete_hit_q;
    assign bus.o_BulletKill = bullet_kill_q;
    assign bus.o_ShipHit    = ship_hit_q;
    assign bus.o_Score      = score_q[c_ScoreW-1:0];
    assign bus.o_Lives      = lives_q;
    assign bus.o_Flash      = flash_q;
    assign bus.o_GameOver   = game_over_q;

endmodule

// File: tb/tb_meteorite_hit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_meteorite_hit_ctrl
// Directed scenarios for meteorite_hit_ctrl (default binary-score build):
// reset, bullet hits, ship hit with flash window, bullet/ship tie, async reset
// mid-flash, game over, off-screen meteorite, restart and score saturation.
// -----------------------------------------------------------------------------
module tb_meteorite_hit_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    meteorite_hit_ctrl_if bus ();

    meteorite_hit_ctrl #(
        .c_GameWidth   (40),
        .c_GameHeight  (30),
        .c_Lives       (3),
        .c_HitPoints   (10),
        .c_ScoreMax    (9999),
        .c_FlashFrames (8)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Place meteorite, bullet and ship for the next frame tick.
    task automatic scene(input logic [5:0] mx, input logic [5:0] my, input logic bv,
                         input logic [5:0] bx, input logic [5:0] by, input logic [5:0] sx);
        bus.i_MeteX       = mx;
        bus.i_MeteY       = my;
        bus.i_BulletValid = bv;
        bus.i_BulletX     = bx;
        bus.i_BulletY     = by;
        bus.i_ShipX       = sx;
    endtask

    // One frame-tick cycle; returns #1 after the edge that registers results.
    task automatic frame_tick();
        bus.i_FrameTick = 1'b1;
        @(posedge clk);
        #1;
        bus.i_FrameTick = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        bus.i_GameActive = 1'b0;
        idle_cycle();
        bus.i_GameActive = 1'b1;
        idle_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_GameActive = 1'b0;
        bus.i_FrameTick  = 1'b0;
        scene(6'd0, 6'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        #12;
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000", {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit});
        end
        checks++;
        if ({bus.o_Score, bus.o_Lives, bus.o_Flash, bus.o_GameOver} !== {14'd0, 3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: score=%0d lives=%0d flash=%b over=%b expected 0/3/0/0",
                     bus.o_Score, bus.o_Lives, bus.o_Flash, bus.o_GameOver);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_GameActive = 1'b1;
        idle_cycle();
    endtask

    task automatic test_bullet_hit();
        scene(6'd12, 6'd5, 1'b1, 6'd12, 6'd5, 6'd0);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b110 || bus.o_Score !== 14'd10) begin
            errors++;
            $display("FAIL bullet_hit: pulses=%b score=%0d expected 110 score=10",
                     {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit}, bus.o_Score);
        end
        idle_cycle();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b000) begin
            errors++;
            $display("FAIL pulse_width: got %b expected 000", {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit});
        end
        // Aligned but no frame tick: nothing happens.
        idle_cycle();
        checks++;
        if (bus.o_MeteHit !== 1'b0 || bus.o_Score !== 14'd10) begin
            errors++;
            $display("FAIL no_tick: mete=%b score=%0d expected 0 score=10", bus.o_MeteHit, bus.o_Score);
        end
        // Bullet one row below the meteorite (step skip) still hits.
        scene(6'd12, 6'd5, 1'b1, 6'd12, 6'd6, 6'd0);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill} !== 2'b11 || bus.o_Score !== 14'd20) begin
            errors++;
            $display("FAIL step_skip: pulses=%b score=%0d expected 11 score=20",
                     {bus.o_MeteHit, bus.o_BulletKill}, bus.o_Score);
        end
        // One row above does not hit.
        scene(6'd12, 6'd5, 1'b1, 6'd12, 6'd4, 6'd0);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill} !== 2'b00 || bus.o_Score !== 14'd20) begin
            errors++;
            $display("FAIL row_above: pulses=%b score=%0d expected 00 score=20",
                     {bus.o_MeteHit, bus.o_BulletKill}, bus.o_Score);
        end
        // Aligned but bullet not in flight.
        scene(6'd12, 6'd5, 1'b0, 6'd12, 6'd5, 6'd0);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill} !== 2'b00) begin
            errors++;
            $display("FAIL bullet_invalid: pulses=%b expected 00", {bus.o_MeteHit, bus.o_BulletKill});
        end
    endtask

    task automatic test_ship_flash();
        scene(6'd7, 6'd28, 1'b0, 6'd0, 6'd0, 6'd7);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b101
            || bus.o_Lives !== 3'd2 || bus.o_Flash !== 1'b1) begin
            errors++;
            $display("FAIL ship_hit: pulses=%b lives=%0d flash=%b expected 101 lives=2 flash=1",
                     {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit}, bus.o_Lives, bus.o_Flash);
        end
        // Flash tick 1: ship hit ignored.
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_ShipHit} !== 2'b00 || bus.o_Lives !== 3'd2 || bus.o_Flash !== 1'b1) begin
            errors++;
            $display("FAIL flash_ship_ignored: pulses=%b lives=%0d flash=%b expected 00 lives=2 flash=1",
                     {bus.o_MeteHit, bus.o_ShipHit}, bus.o_Lives, bus.o_Flash);
        end
        // Flash tick 2: bullet still scores.
        scene(6'd7, 6'd28, 1'b1, 6'd7, 6'd28, 6'd7);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b110 || bus.o_Score !== 14'd30) begin
            errors++;
            $display("FAIL flash_bullet: pulses=%b score=%0d expected 110 score=30",
                     {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit}, bus.o_Score);
        end
        // Flash ticks 3..7.
        scene(6'd20, 6'd10, 1'b0, 6'd0, 6'd0, 6'd7);
        repeat (5) frame_tick();
        checks++;
        if (bus.o_Flash !== 1'b1) begin
            errors++;
            $display("FAIL flash_tick7: flash=%b expected 1", bus.o_Flash);
        end
        // Flash tick 8 ends the window.
        frame_tick();
        checks++;
        if (bus.o_Flash !== 1'b0 || bus.o_Lives !== 3'd2) begin
            errors++;
            $display("FAIL flash_end: flash=%b lives=%0d expected 0 lives=2", bus.o_Flash, bus.o_Lives);
        end
    endtask

    task automatic test_simultaneous();
        scene(6'd7, 6'd28, 1'b1, 6'd7, 6'd28, 6'd7);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b110
            || bus.o_Lives !== 3'd2 || bus.o_Score !== 14'd40 || bus.o_Flash !== 1'b0) begin
            errors++;
            $display("FAIL tie: pulses=%b lives=%0d score=%0d flash=%b expected 110 lives=2 score=40 flash=0",
                     {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit}, bus.o_Lives, bus.o_Score, bus.o_Flash);
        end
    endtask

    task automatic test_reset_mid_flash();
        scene(6'd7, 6'd28, 1'b0, 6'd0, 6'd0, 6'd7);
        frame_tick();
        checks++;
        if (bus.o_Lives !== 3'd1 || bus.o_Flash !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flash: lives=%0d flash=%b expected 1/1", bus.o_Lives, bus.o_Flash);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_Lives !== 3'd3 || bus.o_Flash !== 1'b0 || bus.o_Score !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: lives=%0d flash=%b score=%0d expected 3/0/0",
                     bus.o_Lives, bus.o_Flash, bus.o_Score);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 3; i++) begin
            scene(6'd7, 6'd28, 1'b0, 6'd0, 6'd0, 6'd7);
            frame_tick();
            checks++;
            if (bus.o_ShipHit !== 1'b1 || bus.o_Lives !== 3'(2 - i)) begin
                errors++;
                $display("FAIL life_loss_%0d: ship=%b lives=%0d expected 1 lives=%0d",
                         i, bus.o_ShipHit, bus.o_Lives, 2 - i);
            end
            if (i < 2) begin
                scene(6'd20, 6'd10, 1'b0, 6'd0, 6'd0, 6'd7);
                repeat (8) frame_tick();
            end
        end
        checks++;
        if (bus.o_GameOver !== 1'b1 || bus.o_Flash !== 1'b0) begin
            errors++;
            $display("FAIL game_over: over=%b flash=%b expected 1/0", bus.o_GameOver, bus.o_Flash);
        end
        // Frozen in OVER: aligned bullet gives nothing.
        scene(6'd7, 6'd28, 1'b1, 6'd7, 6'd28, 6'd7);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b000
            || bus.o_Score !== 14'd0 || bus.o_Lives !== 3'd0 || bus.o_GameOver !== 1'b1) begin
            errors++;
            $display("FAIL over_frozen: pulses=%b score=%0d lives=%0d over=%b expected 000 0 0 1",
                     {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit}, bus.o_Score, bus.o_Lives, bus.o_GameOver);
        end
    endtask

    task automatic test_restart_offscreen();
        restart();
        checks++;
        if (bus.o_Score !== 14'd0 || bus.o_Lives !== 3'd3 || bus.o_GameOver !== 1'b0) begin
            errors++;
            $display("FAIL restart: score=%0d lives=%0d over=%b expected 0/3/0",
                     bus.o_Score, bus.o_Lives, bus.o_GameOver);
        end
        scene(6'd40, 6'd30, 1'b1, 6'd40, 6'd30, 6'd40);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit} !== 3'b000) begin
            errors++;
            $display("FAIL offscreen_xy: pulses=%b expected 000", {bus.o_MeteHit, bus.o_BulletKill, bus.o_ShipHit});
        end
        scene(6'd40, 6'd5, 1'b1, 6'd40, 6'd5, 6'd0);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill} !== 2'b00) begin
            errors++;
            $display("FAIL offscreen_x: pulses=%b expected 00", {bus.o_MeteHit, bus.o_BulletKill});
        end
        scene(6'd5, 6'd30, 1'b1, 6'd5, 6'd30, 6'd5);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill} !== 2'b00) begin
            errors++;
            $display("FAIL offscreen_y: pulses=%b expected 00", {bus.o_MeteHit, bus.o_BulletKill});
        end
        // Last on-screen tile still collides.
        scene(6'd39, 6'd29, 1'b1, 6'd39, 6'd29, 6'd0);
        frame_tick();
        checks++;
        if ({bus.o_MeteHit, bus.o_BulletKill} !== 2'b11 || bus.o_Score !== 14'd10) begin
            errors++;
            $display("FAIL edge_tile: pulses=%b score=%0d expected 11 score=10",
                     {bus.o_MeteHit, bus.o_BulletKill}, bus.o_Score);
        end
    endtask

    task automatic test_saturation();
        restart();
        scene(6'd12, 6'd5, 1'b1, 6'd12, 6'd5, 6'd0);
        repeat (999) frame_tick();
        checks++;
        if (bus.o_Score !== 14'd9990) begin
            errors++;
            $display("FAIL score_9990: got %0d expected 9990", bus.o_Score);
        end
        frame_tick();
        checks++;
        if (bus.o_Score !== 14'd9999 || bus.o_MeteHit !== 1'b1) begin
            errors++;
            $display("FAIL score_sat: score=%0d mete=%b expected 9999/1", bus.o_Score, bus.o_MeteHit);
        end
        frame_tick();
        checks++;
        if (bus.o_Score !== 14'd9999) begin
            errors++;
            $display("FAIL score_hold: got %0d expected 9999", bus.o_Score);
        end
    endtask

    initial begin
        test_reset();
        test_bullet_hit();
        test_ship_flash();
        test_simultaneous();
        test_reset_mid_flash();
        test_game_over();
        test_restart_offscreen();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
